// File: rtl/alu_regfile_if.sv
`default_nettype none
// ============================================================================
// Module      : alu_regfile_if
// Description : Operand/result and register-port bundle for alu_regfile.
// Revision    : 1.0 - initial release
// ============================================================================
interface alu_regfile_if #(
    parameter int DATA_W = 32
);
    logic [3:0]        alu_control;
    logic [DATA_W-1:0] src_a;
    logic [DATA_W-1:0] src_b;
    logic [DATA_W-1:0] alu_result;
    logic [4:0]        r1;
    logic [4:0]        r2;
    logic [4:0]        w;
    logic [DATA_W-1:0] data_in;
    logic              we;
    logic [DATA_W-1:0] data_out1;
    logic [DATA_W-1:0] data_out2;

    modport master (
        output alu_control, src_a, src_b, r1, r2, w, data_in, we,
        input  alu_result, data_out1, data_out2
    );

    modport slave (
        input  alu_control, src_a, src_b, r1, r2, w, data_in, we,
        output alu_result, data_out1, data_out2
    );
endinterface
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// ============================================================================
// Module      : alu_regfile
// Description : Combinational ALU plus 32x32 register file (r0 hardwired 0).
//               Define ALU_MULDIV_EN to add signed MUL (code 2) / DIV (code 3).
// Revision    : 1.0 - initial release
// ============================================================================
module alu_regfile #(
    parameter int DATA_W = 32
) (
    input  logic         clk,
    input  logic         resetn,
    alu_regfile_if.slave bus
);
    localparam int         c_NUM_REGS = 32;
    localparam logic [3:0] c_OP_ADD = 4'd0;
    localparam logic [3:0] c_OP_SUB = 4'd1;
    localparam logic [3:0] c_OP_MUL = 4'd2;
    localparam logic [3:0] c_OP_DIV = 4'd3;
    localparam logic [3:0] c_OP_AND = 4'd4;
    localparam logic [3:0] c_OP_OR  = 4'd5;
    localparam logic [3:0] c_OP_XOR = 4'd6;
    localparam logic [3:0] c_OP_LS  = 4'd7;
    localparam logic [3:0] c_OP_RS  = 4'd8;
    localparam logic [3:0] c_OP_EQ  = 4'd9;
    localparam logic [3:0] c_OP_NEQ = 4'd10;
    localparam logic [3:0] c_OP_LT  = 4'd11;
    localparam logic [3:0] c_OP_LTE = 4'd12;
    localparam logic [3:0] c_OP_GT  = 4'd13;
    localparam logic [3:0] c_OP_GTE = 4'd14;

    localparam logic [DATA_W-1:0] c_ZERO = '0;
    localparam logic [DATA_W-1:0] c_ONE  = {{(DATA_W-1){1'b0}}, 1'b1};

    logic signed [DATA_W-1:0] w_sa;
    logic signed [DATA_W-1:0] w_sb;
    logic        [DATA_W-1:0] w_alu;

    assign w_sa = $signed(bus.src_a);
    assign w_sb = $signed(bus.src_b);

`ifdef ALU_MULDIV_EN
    localparam logic [DATA_W-1:0] c_INT_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W-1:0] w_mul;
    logic [DATA_W-1:0] w_div;

    // Low half of a product is the same for signed and unsigned operands.
    assign w_mul = bus.src_a * bus.src_b;

    always_comb begin
        w_div = '0;
        if (bus.src_b == c_ZERO) begin
            w_div = '1;
        end else if ((bus.src_a == c_INT_MIN) && (bus.src_b == '1)) begin
            w_div = c_INT_MIN;
        end else begin
            w_div = w_sa / w_sb;
        end
    end
`endif

    always_comb begin
        w_alu = '0;
        case (bus.alu_control)
            c_OP_ADD: w_alu = bus.src_a + bus.src_b;
            c_OP_SUB: w_alu = bus.src_a - bus.src_b;
`ifdef ALU_MULDIV_EN
            c_OP_MUL: w_alu = w_mul;
            c_OP_DIV: w_alu = w_div;
`else
            c_OP_MUL: w_alu = '0;
            c_OP_DIV: w_alu = '0;
`endif
            c_OP_AND: w_alu = bus.src_a & bus.src_b;
            c_OP_OR:  w_alu = bus.src_a | bus.src_b;
            c_OP_XOR: w_alu = bus.src_a ^ bus.src_b;
            c_OP_LS:  w_alu = bus.src_a << bus.src_b[4:0];
            c_OP_RS:  w_alu = bus.src_a >> bus.src_b[4:0];
            c_OP_EQ:  w_alu = (bus.src_a == bus.src_b) ? c_ONE : c_ZERO;
            c_OP_NEQ: w_alu = (bus.src_a != bus.src_b) ? c_ONE : c_ZERO;
            c_OP_LT:  w_alu = (w_sa <  w_sb) ? c_ONE : c_ZERO;
            c_OP_LTE: w_alu = (w_sa <= w_sb) ? c_ONE : c_ZERO;
            c_OP_GT:  w_alu = (w_sa >  w_sb) ? c_ONE : c_ZERO;
            c_OP_GTE: w_alu = (w_sa >= w_sb) ? c_ONE : c_ZERO;
            default:  w_alu = '0;
        endcase
    end

    assign bus.alu_result = w_alu;

    logic [DATA_W-1:0] regs_q [c_NUM_REGS];
    logic              w_wr_en;

    assign w_wr_en = bus.we && (bus.w != 5'd0);

    // Reset wins over a concurrent write; r0 is never written.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (w_wr_en) begin
            regs_q[bus.w] <= bus.data_in;
        end
    end

    assign bus.data_out1 = (bus.r1 == 5'd0) ? c_ZERO : regs_q[bus.r1];
    assign bus.data_out2 = (bus.r2 == 5'd0) ? c_ZERO : regs_q[bus.r2];
endmodule
`default_nettype wire

// File: tb/tb_alu_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_regfile
// Description : Scoreboard bench for alu_regfile; honours ALU_MULDIV_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_regfile;
    logic clk;
    logic resetn;

    alu_regfile_if #(.DATA_W(32)) bus ();

    alu_regfile #(.DATA_W(32)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] alu;
        logic [31:0] d1;
        logic [31:0] d2;
    } exp_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
        string       name;
    } vec_t;

    exp_t        sb_q[$];
    logic [31:0] model [32];
    logic        chk_v;
    int          errors;
    int          checks;

    // Reference ALU written straight from the operation definitions.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int     sa;
        int     sb;
        longint p;
        sa = $signed(a);
        sb = $signed(b);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
`ifdef ALU_MULDIV_EN
            4'd2: begin
                p = longint'(sa) * longint'(sb);
                return p[31:0];
            end
            4'd3: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return sa / sb;
            end
`endif
            4'd4:  return a & b;
            4'd5:  return a | b;
            4'd6:  return a ^ b;
            4'd7:  return a << (b % 32);
            4'd8:  return a >> (b % 32);
            4'd9:  return (a == b) ? 32'd1 : 32'd0;
            4'd10: return (a != b) ? 32'd1 : 32'd0;
            4'd11: return (sa <  sb) ? 32'd1 : 32'd0;
            4'd12: return (sa <= sb) ? 32'd1 : 32'd0;
            4'd13: return (sa >  sb) ? 32'd1 : 32'd0;
            4'd14: return (sa >= sb) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] ref_rd(input logic [4:0] r);
        return (r == 5'd0) ? 32'd0 : model[r];
    endfunction

    // One cycle of stimulus: expectation is taken from the pre-edge model.
    task automatic drive(input logic rn, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] r1, input logic [4:0] r2,
                         input logic [4:0] w, input logic [31:0] din, input logic we_v,
                         input string nm, input logic lit_v, input logic [31:0] lit);
        exp_t e;
        resetn          = rn;
        bus.alu_control = op;
        bus.src_a       = a;
        bus.src_b       = b;
        bus.r1          = r1;
        bus.r2          = r2;
        bus.w           = w;
        bus.data_in     = din;
        bus.we          = we_v;
        e.name = nm;
        e.alu  = lit_v ? lit : ref_alu(op, a, b);
        e.d1   = ref_rd(r1);
        e.d2   = ref_rd(r2);
        sb_q.push_back(e);
        chk_v = 1'b1;
        @(posedge clk);
        if (!rn) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
        end else if (we_v && w != 5'd0) begin
            model[w] = din;
        end
        #1;
    endtask

    task automatic rd(input logic [4:0] r1, input logic [4:0] r2, input string nm);
        drive(1'b1, 4'd15, 32'd0, 32'd0, r1, r2, 5'd0, 32'd0, 1'b0, nm, 1'b0, 32'd0);
    endtask

    always @(negedge clk) begin
        if (chk_v) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_empty: output presented with no expectation queued");
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                checks += 3;
                if (bus.alu_result !== e.alu) begin
                    errors++;
                    $display("FAIL %s alu_result: got %h want %h", e.name, bus.alu_result, e.alu);
                end
                if (bus.data_out1 !== e.d1) begin
                    errors++;
                    $display("FAIL %s data_out1: got %h want %h", e.name, bus.data_out1, e.d1);
                end
                if (bus.data_out2 !== e.d2) begin
                    errors++;
                    $display("FAIL %s data_out2: got %h want %h", e.name, bus.data_out2, e.d2);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        vec_t vt[$];
        errors = 0;
        checks = 0;
        chk_v  = 1'b0;
        resetn = 1'b0;
        bus.alu_control = 4'd0;
        bus.src_a = 32'd0;
        bus.src_b = 32'd0;
        bus.r1 = 5'd0;
        bus.r2 = 5'd0;
        bus.w = 5'd0;
        bus.data_in = 32'd0;
        bus.we = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        #1;

        rd(5'd5, 5'd31, "reset_read");
        drive(1'b1, 4'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd3, 32'hDEAD_BEEF, 1'b1, "wr3", 1'b0, 32'd0);
        drive(1'b1, 4'd0, 32'd0, 32'd0, 5'd3, 5'd0, 5'd0, 32'd7, 1'b1, "wr0", 1'b0, 32'd0);
        rd(5'd3, 5'd0, "rd3_rd0");
        drive(1'b1, 4'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd4, 32'd10, 1'b1, "wr4", 1'b0, 32'd0);
        drive(1'b1, 4'd0, 32'd0, 32'd0, 5'd4, 5'd4, 5'd4, 32'd20, 1'b1, "rw4_old", 1'b0, 32'd0);
        rd(5'd4, 5'd4, "rw4_new");

        vt.push_back('{4'd0,  32'hFFFF_FFFF, 32'd1,        32'd0,        "add_wrap"});
        vt.push_back('{4'd1,  32'd5,         32'd7,        32'hFFFF_FFFE, "sub_neg"});
        vt.push_back('{4'd7,  32'd1,         32'd33,       32'd2,        "ls_mod"});
        vt.push_back('{4'd8,  32'h8000_0000, 32'd4,        32'h0800_0000, "rs_logic"});
        vt.push_back('{4'd6,  32'hF0F0_F0F0, 32'hFF,       32'hF0F0_F00F, "xor"});
        vt.push_back('{4'd11, 32'hFFFF_FFFF, 32'd1,        32'd1,        "lt_signed"});
        vt.push_back('{4'd13, 32'hFFFF_FFFF, 32'd1,        32'd0,        "gt_signed"});
        vt.push_back('{4'd14, 32'hFFFF_FFFF, 32'd1,        32'd0,        "gte_signed"});
        vt.push_back('{4'd10, 32'hFFFF_FFFF, 32'd1,        32'd1,        "neq"});
        vt.push_back('{4'd9,  32'd9,         32'd9,        32'd1,        "eq"});
        vt.push_back('{4'd12, 32'd9,         32'd9,        32'd1,        "lte_eq"});
        vt.push_back('{4'd15, 32'hFFFF_FFFF, 32'd1,        32'd0,        "code15"});
`ifdef ALU_MULDIV_EN
        vt.push_back('{4'd2,  32'hFFFF_FFFD, 32'd4,        32'hFFFF_FFF4, "mul"});
        vt.push_back('{4'd3,  32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, "div"});
        vt.push_back('{4'd3,  32'd5,         32'd0,        32'hFFFF_FFFF, "div0"});
        vt.push_back('{4'd3,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "div_ovf"});
`else
        vt.push_back('{4'd2,  32'hFFFF_FFFD, 32'd4,        32'd0,        "mul_off"});
        vt.push_back('{4'd3,  32'hFFFF_FFF9, 32'd2,        32'd0,        "div_off"});
`endif
        foreach (vt[k]) begin
            drive(1'b1, vt[k].op, vt[k].a, vt[k].b, 5'd3, 5'd4, 5'd0, 32'd0, 1'b0,
                  vt[k].name, 1'b1, vt[k].e);
        end

        // Fill a few registers, then reset alongside a write and sweep every address.
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 4'd0, 32'd0, 32'd0, 5'(i), 5'd0, 5'(i), $urandom, 1'b1, "fill",
                  1'b0, 32'd0);
        end
        drive(1'b0, 4'd6, 32'h1234_5678, 32'hFFFF_0000, 5'd2, 5'd3, 5'd6, 32'hCAFE_F00D, 1'b1,
              "rst_vs_wr", 1'b0, 32'd0);
        for (int i = 0; i < 32; i++) begin
            rd(5'(i), 5'(31 - i), "post_rst_sweep");
        end

        for (int n = 0; n < 300; n++) begin
            logic [31:0] a;
            logic [31:0] b;
            logic [4:0]  r1;
            logic [4:0]  r2;
            case ($urandom_range(0, 3))
                0:       a = 32'h8000_0000;
                1:       a = 32'hFFFF_FFFF;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0:       b = 32'(a);
                1:       b = 32'(-$signed(1));
                2:       b = $urandom_range(0, 40);
                default: b = $urandom;
            endcase
            r1 = 5'($urandom_range(0, 31));
            r2 = ($urandom_range(0, 7) == 0) ? r1 : 5'($urandom_range(0, 31));
            drive(($urandom_range(0, 39) != 0), 4'($urandom_range(0, 15)), a, b, r1, r2,
                  5'($urandom_range(0, 31)), $urandom, 1'($urandom_range(0, 1)), "random",
                  1'b0, 32'd0);
        end
        chk_v = 1'b0;

        repeat (2) @(posedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations want 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/alu_regfile.md
ALU_REGFILE -- requirements
Module: alu_regfile

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, the datapath and register width; only 32 is required to be supported.
REQ-002 The block SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 The block SHALL have port resetn, input, 1 bit: reset, synchronous, active-low; clock clk.
REQ-004 The block SHALL have port alu_control, input, 4 bits: ALU operation select.
REQ-005 The block SHALL have ports src_a and src_b, input, 32 bits each: ALU operands.
REQ-006 The block SHALL have port alu_result, output, 32 bits: ALU result.
REQ-007 The block SHALL have ports r1 and r2, input, 5 bits each: register read addresses.
REQ-008 The block SHALL have port w, input, 5 bits: register write address.
REQ-009 The block SHALL have port data_in, input, 32 bits: register write data.
REQ-010 The block SHALL have port we, input, 1 bit: register write enable.
REQ-011 The block SHALL have ports data_out1 and data_out2, output, 32 bits each: contents of register r1 and register r2.

Function
REQ-012 The ALU SHALL be purely combinational, with alu_result settling within the same cycle as its inputs and no clock or reset dependence.
REQ-013 The ALU SHALL implement these alu_control codes:
- 0 ADD: a+b.
- 1 SUB: a-b.
- 4 AND.
- 5 OR.
- 6 XOR.
- 7 LS: a << b[4:0].
- 8 RS: logical a >> b[4:0].
REQ-014 ADD and SUB SHALL be modulo 2^32 and wrap with no overflow flag; shift amounts SHALL use only b[4:0].
REQ-015 The compare codes SHALL output 32'd1 when true and 32'd0 when false:
- 9 EQ, 10 NEQ: equality.
- 11 LT, 12 LTE, 13 GT, 14 GTE: two's-complement signed compare.
REQ-016 Code 15 and any unimplemented code SHALL produce 32'd0.
REQ-017 The register file SHALL contain 32 registers of 32 bits.
REQ-018 Register 0 SHALL always read 0, and writes to it SHALL be ignored.
REQ-019 Reads SHALL be asynchronous: data_out1 = reg[r1] and data_out2 = reg[r2] combinationally.
REQ-020 A write SHALL occur on the rising clk edge when resetn=1, we=1 and w!=0, storing data_in into reg[w].
REQ-021 When a read and a write target the same register in the same cycle, the read SHALL return the old value until the edge and the new value after it, with no bypass.
REQ-022 When r1 equals r2, both outputs SHALL show the same value.

Reset
REQ-023 When resetn=0 on a rising clk edge, all 32 registers SHALL clear to 0.
REQ-024 Reset SHALL take priority over a simultaneous write.
REQ-025 After reset, data_out1 and data_out2 SHALL read 0 for every address.
REQ-026 Asserting reset in the middle of a write sequence SHALL discard that cycle's write.
REQ-027 alu_result SHALL depend only on its inputs and SHALL be unaffected by reset.

Configuration
REQ-028 With macro ALU_MULDIV_EN defined, the ALU SHALL implement:
- Code 2 MUL: low 32 bits of the signed product.
- Code 3 DIV: signed quotient truncated toward zero.
- Divide by zero: 32'hFFFFFFFF.
- 32'h80000000 / -1: 32'h80000000.
REQ-029 With ALU_MULDIV_EN undefined, codes 2 and 3 SHALL produce 32'd0 and no multiplier or divider SHALL be synthesized.

Verification
REQ-030 Reset then read: hold resetn=0 for 1 edge, release, read r1=5 and r2=31 -> data_out1=0, data_out2=0.
REQ-031 Write/read: we=1, w=3, data_in=32'hDEADBEEF, one edge, then r1=3 -> data_out1=32'hDEADBEEF. Repeat with w=0 and data_in=7 -> r2=0 reads 0.
REQ-032 Same-cycle read/write: reg[4]=10, r1=4, we=1, w=4, data_in=20 -> data_out1=10 before the edge and 20 after it.
REQ-033 ALU arithmetic and logic:
- ADD 32'hFFFFFFFF+1 -> 0.
- SUB 5-7 -> 32'hFFFFFFFE.
- LS 1<<33 -> 2.
- RS 32'h80000000>>4 -> 32'h08000000.
- XOR 32'hF0F0F0F0 with 32'hFF -> 32'hF0F0F00F.
REQ-034 ALU compares with a=-1 (32'hFFFFFFFF) and b=1:
- LT -> 1, GT -> 0, GTE -> 0, NEQ -> 1.
- With a=b=9: EQ -> 1, LTE -> 1.
- Code 15 -> 0.
REQ-035 MUL/DIV:
- With ALU_MULDIV_EN: MUL -3*4 -> 32'hFFFFFFF4; DIV -7/2 -> 32'hFFFFFFFD; DIV 5/0 -> 32'hFFFFFFFF.
- Without ALU_MULDIV_EN: MUL -3*4 -> 0 and DIV -7/2 -> 0.
